// File: rtl/chess_key_pkg.sv
// Shared scancodes, key_event field positions, FSM states and command decode
// for the keyboard command path.
package chess_key_pkg;

    localparam logic [7:0] SC_I        = 8'h43;
    localparam logic [7:0] SC_W        = 8'h1D;
    localparam logic [7:0] SC_K        = 8'h42;
    localparam logic [7:0] SC_S        = 8'h1B;
    localparam logic [7:0] SC_J        = 8'h3B;
    localparam logic [7:0] SC_A        = 8'h1C;
    localparam logic [7:0] SC_L        = 8'h4B;
    localparam logic [7:0] SC_D        = 8'h23;
    localparam logic [7:0] SC_SPACE    = 8'h29;
    localparam logic [7:0] SC_G        = 8'h34;
    localparam logic [7:0] SC_E0_UP    = 8'h75;
    localparam logic [7:0] SC_E0_DOWN  = 8'h72;
    localparam logic [7:0] SC_E0_LEFT  = 8'h6B;
    localparam logic [7:0] SC_E0_RIGHT = 8'h74;

    localparam int unsigned KE_VALID = 10;
    localparam int unsigned KE_EXT   = 9;
    localparam int unsigned KE_BRK   = 8;

    typedef enum logic [1:0] {IDLE, HELD_NOREP, DELAY, REPEAT} state_t;

    typedef enum logic [2:0] {
        CMD_NONE, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_SEL, CMD_PROMO
    } cmd_t;

    // Arrow codes only count with the E0 prefix; letter codes only without it.
    function automatic cmd_t decode_key(input logic ext, input logic [7:0] code);
        cmd_t c;
        c = CMD_NONE;
        if (ext) begin
            case (code)
                SC_E0_UP:    c = CMD_UP;
                SC_E0_DOWN:  c = CMD_DOWN;
                SC_E0_LEFT:  c = CMD_LEFT;
                SC_E0_RIGHT: c = CMD_RIGHT;
                default:     c = CMD_NONE;
            endcase
        end else begin
            case (code)
                SC_I, SC_W: c = CMD_UP;
                SC_K, SC_S: c = CMD_DOWN;
                SC_J, SC_A: c = CMD_LEFT;
                SC_L, SC_D: c = CMD_RIGHT;
                SC_SPACE:   c = CMD_SEL;
                SC_G:       c = CMD_PROMO;
                default:    c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

    function automatic logic is_dir(input cmd_t c);
        return (c == CMD_UP) || (c == CMD_DOWN) || (c == CMD_LEFT) || (c == CMD_RIGHT);
    endfunction

endpackage

// File: rtl/hold_repeat_timer.sv
// Hold counter for cursor auto-repeat: ticks after REPEAT_DELAY cycles in the
// delay phase and every REPEAT_PERIOD cycles in the period phase.
module hold_repeat_timer #(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 15_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic run,
    input  logic phase,
    output logic tick
);
    import chess_key_pkg::*;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;

    always_comb begin
        limit = phase ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
        // A clear in the expiry cycle suppresses the tick so no double step occurs.
        tick  = run && !clear && (cnt == limit);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear || tick || !run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_cmd_decoder.sv
// Turns PS/2 key events into board-cursor moves and select/promotion pulses,
// tracking one active key with its own hold-to-repeat.
module key_cmd_decoder #(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 15_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [10:0] key_event,
    input  logic        en,
    output logic [2:0]  cursor_x,
    output logic [2:0]  cursor_y,
    output logic        select_pulse,
    output logic        promo_pulse,
    output logic        move_pulse,
    output logic        key_held
);
    import chess_key_pkg::*;

    state_t     state;
    logic [8:0] active;
    logic [8:0] ev_key;
    cmd_t       ev_cmd;
    cmd_t       act_cmd;
    cmd_t       step_cmd;
    logic       ev_valid;
    logic       take;
    logic       drop;
    logic       tracking;
    logic       timer_clear;
    logic       tick;

    always_comb begin
        ev_valid    = en && key_event[KE_VALID];
        ev_key      = {key_event[KE_EXT], key_event[7:0]};
        ev_cmd      = decode_key(key_event[KE_EXT], key_event[7:0]);
        act_cmd     = decode_key(active[8], active[7:0]);
        // Typematic makes of the active key are not "taken", so they never disturb timing.
        take        = ev_valid && !key_event[KE_BRK] && (ev_cmd != CMD_NONE)
                      && !((state != IDLE) && (ev_key == active));
        drop        = ev_valid && key_event[KE_BRK] && (state != IDLE) && (ev_key == active);
        tracking    = (state == DELAY) || (state == REPEAT);
        timer_clear = !en || !tracking || take || drop;
        step_cmd    = CMD_NONE;
        if (take)      step_cmd = ev_cmd;
        else if (tick) step_cmd = act_cmd;
    end

    hold_repeat_timer #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .clear (timer_clear),
        .run   (en && tracking),
        .phase (state == REPEAT),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            active       <= '0;
            cursor_x     <= '0;
            cursor_y     <= '0;
            select_pulse <= 1'b0;
            promo_pulse  <= 1'b0;
            move_pulse   <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            select_pulse <= (step_cmd == CMD_SEL);
            promo_pulse  <= (step_cmd == CMD_PROMO);
            move_pulse   <= is_dir(step_cmd);
            case (step_cmd)
                CMD_UP:    cursor_y <= cursor_y - 3'd1;
                CMD_DOWN:  cursor_y <= cursor_y + 3'd1;
                CMD_LEFT:  cursor_x <= cursor_x - 3'd1;
                CMD_RIGHT: cursor_x <= cursor_x + 3'd1;
                default:   ;
            endcase

            if (!en) begin
                state    <= IDLE;
                key_held <= 1'b0;
            end else if (take) begin
                active   <= ev_key;
                state    <= is_dir(ev_cmd) ? DELAY : HELD_NOREP;
                key_held <= 1'b1;
            end else if (drop) begin
                state    <= IDLE;
                key_held <= 1'b0;
            end else if (tick && (state == DELAY)) begin
                state    <= REPEAT;
            end
        end
    end

endmodule
